multiplier_arbiter_taint: RTL

- Shares one taint-tracked constant-time multiplier between two requesters.
- Per-requester operand capture, round-robin arbitration, multiplier start sequencing, and result return.
- Shadow `_t` taint bits on every control and data signal, with control-flow taint folded into outputs.
- Sits between the requesting units and the multiplier's start/operand/productDone/product interface.

---
 rtl/multiplier_arbiter_taint.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/multiplier_arbiter_taint.sv
// Two-requester front end for a shared constant-time multiplier, with shadow
// taint tracking on every control and data path.
module multiplier_arbiter_taint #(
    parameter int WIDTH = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req0_i,
    input  logic                 req0_t_i,
    input  logic [WIDTH-1:0]     req0_a_i,
    input  logic [WIDTH-1:0]     req0_a_t_i,
    input  logic [WIDTH-1:0]     req0_b_i,
    input  logic [WIDTH-1:0]     req0_b_t_i,
    input  logic                 req1_i,
    input  logic                 req1_t_i,
    input  logic [WIDTH-1:0]     req1_a_i,
    input  logic [WIDTH-1:0]     req1_a_t_i,
    input  logic [WIDTH-1:0]     req1_b_i,
    input  logic [WIDTH-1:0]     req1_b_t_i,
    output logic                 gnt0_o,
    output logic                 gnt0_t_o,
    output logic                 gnt1_o,
    output logic                 gnt1_t_o,
    output logic                 mul_start_o,
    output logic                 mul_start_t_o,
    output logic [WIDTH-1:0]     mul_a_o,
    output logic [WIDTH-1:0]     mul_a_t_o,
    output logic [WIDTH-1:0]     mul_b_o,
    output logic [WIDTH-1:0]     mul_b_t_o,
    input  logic                 mul_done_i,
    input  logic                 mul_done_t_i,
    input  logic [2*WIDTH-1:0]   mul_product_i,
    input  logic [2*WIDTH-1:0]   mul_product_t_i,
    output logic                 resp_valid_o,
    output logic                 resp_valid_t_o,
    output logic                 resp_id_o,
    output logic                 resp_id_t_o,
    output logic [2*WIDTH-1:0]   resp_product_o,
    output logic [2*WIDTH-1:0]   resp_product_t_o,
    output logic                 busy_o,
    output logic                 busy_t_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 last_q, last_d;
    logic                 owner_q, owner_d;
    logic                 fsm_t_q, fsm_t_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_a_t_q, mul_a_t_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [WIDTH-1:0]     mul_b_t_q, mul_b_t_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   prod_t_q, prod_t_d;
    logic                 gnt0_q, gnt0_d;
    logic                 gnt1_q, gnt1_d;
    logic                 mul_start_q, mul_start_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 busy_q, busy_d;
    logic                 grant0_s;
    logic                 grant1_s;

    // Round-robin pick: on a tie the requester not granted last wins.
    assign grant0_s = req0_i & (~req1_i | last_q);
    assign grant1_s = req1_i & (~req0_i | ~last_q);

    // Next-state, capture and one-cycle pulse decode.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        fsm_t_d      = fsm_t_q;
        mul_a_d      = mul_a_q;
        mul_a_t_d    = mul_a_t_q;
        mul_b_d      = mul_b_q;
        mul_b_t_d    = mul_b_t_q;
        prod_d       = prod_q;
        prod_t_d     = prod_t_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        mul_start_d  = 1'b0;
        resp_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Tie resolution depends on both requests, so both taints flow into control.
                if (req0_i || req1_i || req0_t_i || req1_t_i) begin
                    fsm_t_d = req0_t_i | req1_t_i;
                end else begin
                    fsm_t_d = 1'b0;
                end
                if (grant0_s) begin
                    gnt0_d    = 1'b1;
                    mul_a_d   = req0_a_i;
                    mul_a_t_d = req0_a_t_i;
                    mul_b_d   = req0_b_i;
                    mul_b_t_d = req0_b_t_i;
                    owner_d   = 1'b0;
                    last_d    = 1'b0;
                    state_d   = S_LAUNCH;
                end else if (grant1_s) begin
                    gnt1_d    = 1'b1;
                    mul_a_d   = req1_a_i;
                    mul_a_t_d = req1_a_t_i;
                    mul_b_d   = req1_b_i;
                    mul_b_t_d = req1_b_t_i;
                    owner_d   = 1'b1;
                    last_d    = 1'b1;
                    state_d   = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                mul_start_d = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                fsm_t_d = fsm_t_q | mul_done_t_i;
                if (mul_done_i) begin
                    prod_d   = mul_product_i;
                    prod_t_d = mul_product_t_i;
                    state_d  = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            fsm_t_q      <= 1'b0;
            mul_a_q      <= '0;
            mul_a_t_q    <= '0;
            mul_b_q      <= '0;
            mul_b_t_q    <= '0;
            prod_q       <= '0;
            prod_t_q     <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            mul_start_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            fsm_t_q      <= fsm_t_d;
            mul_a_q      <= mul_a_d;
            mul_a_t_q    <= mul_a_t_d;
            mul_b_q      <= mul_b_d;
            mul_b_t_q    <= mul_b_t_d;
            prod_q       <= prod_d;
            prod_t_q     <= prod_t_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            mul_start_q  <= mul_start_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt0_o           = gnt0_q;
    assign gnt1_o           = gnt1_q;
    assign mul_start_o      = mul_start_q;
    assign mul_a_o          = mul_a_q;
    assign mul_a_t_o        = mul_a_t_q;
    assign mul_b_o          = mul_b_q;
    assign mul_b_t_o        = mul_b_t_q;
    assign resp_valid_o     = resp_valid_q;
    assign resp_id_o        = owner_q;
    assign resp_product_o   = prod_q;
    assign busy_o           = busy_q;

    // Control-flow taint reaches every control output and smears over the result.
    assign gnt0_t_o         = fsm_t_q;
    assign gnt1_t_o         = fsm_t_q;
    assign mul_start_t_o    = fsm_t_q;
    assign resp_valid_t_o   = fsm_t_q;
    assign resp_id_t_o      = fsm_t_q;
    assign busy_t_o         = fsm_t_q;
    assign resp_product_t_o = prod_t_q | {(2*WIDTH){fsm_t_q}};

endmodule
